// File: rtl/generateproof_deadlock_report_if.sv
// -----------------------------------------------------------------------------
// generateproof_deadlock_report_if
// Report channel from the deadlock reporter to the debug/host side.
//   rpt_valid  report available (producer -> consumer)
//   rpt_ready  consumer accepts the report (consumer -> producer)
//   rpt_idx    index of the blocking monitor
//   rpt_time   timestamp (cycles since reset) at detection
// Modports: master = report producer, slave = report consumer.
// -----------------------------------------------------------------------------
interface generateproof_deadlock_report_if #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 32
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [IDX_W-1:0] rpt_idx;
    logic [CNT_W-1:0] rpt_time;

    modport master (
        output rpt_valid,
        output rpt_idx,
        output rpt_time,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_idx,
        input  rpt_time,
        output rpt_ready
    );
endinterface

// File: rtl/generateproof_deadlock_report.sv
// -----------------------------------------------------------------------------
// generateproof_deadlock_report
// Collects the block flags of the per-instance HLS deadlock monitors, filters
// them for persistence, picks the first sustained blocker, timestamps it and
// emits a single report on a valid/ready channel. A sticky deadlock flag stays
// set until software pulses clear.
//
// Ports:
//   clock     single clock, rising edge
//   reset     asynchronous active-low reset
//   block_in  [N_MON] registered block flags from the monitors
//   clear     one-cycle pulse: drop report and sticky flag, re-arm
//   deadlock  sticky deadlock flag
//   rpt       report channel (master modport: rpt_valid/rpt_idx/rpt_time out,
//             rpt_ready in)
//
// Optional feature macro: DEADLOCK_RPT_AUTOREARM_EN
//   defined   : after a report is accepted, the first cycle with no block
//               re-arms detection (deadlock stays set until clear)
//   undefined : once a report is accepted, only clear re-arms detection
// -----------------------------------------------------------------------------
module generateproof_deadlock_report #(
    parameter int N_MON   = 4,
    parameter int PERSIST = 16,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = (N_MON > 1) ? $clog2(N_MON) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_MON-1:0]     block_in,
    input  logic                 clear,
    output logic                 deadlock,
    generateproof_deadlock_report_if.master rpt
);

    localparam int CNT_PW = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WATCH   = 2'd1,
        REPORT  = 2'd2,
        LATCHED = 2'd3
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    cand_r;
    logic [CNT_PW-1:0]   cnt_r;
    logic [CNT_W-1:0]    ts_r;
    logic                rpt_valid_r;
    logic [IDX_W-1:0]    rpt_idx_r;
    logic [CNT_W-1:0]    rpt_time_r;
    logic                deadlock_r;

    // Lowest set index of a block vector; the lowest monitor wins ties.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_MON-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = N_MON - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Free-running saturating timestamp plus the detection/report FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cand_r      <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_PW{1'b0}};
            ts_r        <= {CNT_W{1'b0}};
            rpt_valid_r <= 1'b0;
            rpt_idx_r   <= {IDX_W{1'b0}};
            rpt_time_r  <= {CNT_W{1'b0}};
            deadlock_r  <= 1'b0;
        end else begin
            // The timestamp is not affected by clear, only by reset.
            if (ts_r != {CNT_W{1'b1}}) begin
                ts_r <= ts_r + CNT_W'(1);
            end else begin
                ts_r <= ts_r;
            end

            if (clear) begin
                // Clear beats everything, including a same-edge handshake;
                // rpt_idx/rpt_time deliberately keep their last values.
                state_r     <= IDLE;
                cand_r      <= {IDX_W{1'b0}};
                cnt_r       <= {CNT_PW{1'b0}};
                rpt_valid_r <= 1'b0;
                deadlock_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (block_in != {N_MON{1'b0}}) begin
                            cand_r  <= lowest_set(block_in);
                            cnt_r   <= CNT_PW'(1);
                            state_r <= WATCH;
                        end else begin
                            cnt_r   <= {CNT_PW{1'b0}};
                        end
                    end
                    WATCH: begin
                        if (block_in[cand_r]) begin
                            // cnt counts consecutive high samples of the candidate.
                            if (cnt_r + CNT_PW'(1) == CNT_PW'(PERSIST)) begin
                                state_r     <= REPORT;
                                cnt_r       <= {CNT_PW{1'b0}};
                                rpt_valid_r <= 1'b1;
                                rpt_idx_r   <= cand_r;
                                rpt_time_r  <= ts_r;
                                deadlock_r  <= 1'b1;
                            end else begin
                                cnt_r <= cnt_r + CNT_PW'(1);
                            end
                        end else if (block_in != {N_MON{1'b0}}) begin
                            // Candidate let go but someone else is blocking:
                            // restart the persistence window on the new one.
                            cand_r <= lowest_set(block_in);
                            cnt_r  <= CNT_PW'(1);
                        end else begin
                            cnt_r   <= {CNT_PW{1'b0}};
                            state_r <= IDLE;
                        end
                    end
                    REPORT: begin
                        if (rpt.rpt_ready) begin
                            rpt_valid_r <= 1'b0;
                            state_r     <= LATCHED;
                        end else begin
                            rpt_valid_r <= 1'b1;
                        end
                    end
                    LATCHED: begin
`ifdef DEADLOCK_RPT_AUTOREARM_EN
                        if (block_in == {N_MON{1'b0}}) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= LATCHED;
                        end
`else
                        state_r <= LATCHED;
`endif
                    end
                    default: begin
                        state_r     <= IDLE;
                        cnt_r       <= {CNT_PW{1'b0}};
                        rpt_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rpt.rpt_valid = rpt_valid_r;
    assign rpt.rpt_idx   = rpt_idx_r;
    assign rpt.rpt_time  = rpt_time_r;
    assign deadlock      = deadlock_r;

endmodule
